pwr_mac_acc: RTL

//  Downstream stage of the low-power gated-multiplier datapath. Consumes the 16-bit

---
 rtl/pwr_mac_pkg.sv | 7 +
 rtl/pwr_sat_add.sv | 21 ++
 rtl/pwr_mac_acc.sv | 75 +++++++
 3 files changed

// File: rtl/pwr_mac_pkg.sv
// pwr_mac_pkg: shared state encoding and default widths for the gated MAC accumulator
package pwr_mac_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  localparam int PROD_W_DEF = 16;
  localparam int ACC_W_DEF = 24;
  localparam int FRAME_LEN_DEF = 16;
endpackage

// File: rtl/pwr_sat_add.sv
// pwr_sat_add: W-bit adder, clamps at all-ones when PWR_ACC_SAT_EN is defined, else wraps
//   a_i, b_i : addends      sum_o : clamped or wrapped sum
//   ovf_o    : carry out of the add (saturating build only, else 0)
module pwr_sat_add #(
  parameter int W = 24
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);
`ifdef PWR_ACC_SAT_EN
  logic [W:0] t;
  assign t = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o = t[W] ? '1 : t[W-1:0];
  assign ovf_o = t[W];
`else
  assign sum_o = a_i + b_i;
  assign ovf_o = 1'b0;
`endif
endmodule

// File: rtl/pwr_mac_acc.sv
// pwr_mac_acc: sums FRAME_LEN unsigned products on gated clock AB_clk, hands off over valid/ready
//   AB_clk, rst (sync, active-high)
//   start                       : begin a frame (IDLE, or HOLD on handoff)
//   prod_in/prod_valid/prod_ready : product input handshake
//   acc_out/acc_valid/acc_ready   : frame sum output handshake
//   busy                        : in ACCUM or HOLD
//   sat_flag                    : frame clamped (only with PWR_ACC_SAT_EN, else 0)
module pwr_mac_acc import pwr_mac_pkg::*; #(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic              AB_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              busy,
  output logic              sat_flag
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, out_q, out_d, sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic vld_q, vld_d, sat_q, sat_d, ovf;
  logic accept, last, handoff, clr;
  pwr_sat_add #(.W(ACC_W)) u_add (
    .a_i  (acc_q),
    .b_i  (ACC_W'(prod_in)),
    .sum_o(sum),
    .ovf_o(ovf)
  );
  assign prod_ready = state_q == ACCUM;
  assign busy = state_q != IDLE;
  assign acc_out = out_q;
  assign acc_valid = vld_q;
  assign sat_flag = sat_q;
  assign accept = prod_ready && prod_valid;
  assign last = cnt_q == CNT_W'(FRAME_LEN - 1);
  assign handoff = state_q == HOLD && vld_q && acc_ready;
  // a new frame starts from IDLE or directly out of a handoff, with no idle gap
  assign clr = start && (state_q == IDLE || handoff);
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = start ? ACCUM : IDLE;
    else if (state_q == ACCUM) state_d = (accept && last) ? HOLD : ACCUM;
    else if (handoff) state_d = start ? ACCUM : IDLE;
    acc_d = clr ? '0 : accept ? sum : acc_q;
    cnt_d = clr ? '0 : accept ? cnt_q + CNT_W'(1) : cnt_q;
    out_d = (accept && last) ? sum : out_q;
    vld_d = (accept && last) ? 1'b1 : handoff ? 1'b0 : vld_q;
    sat_d = clr ? 1'b0 : (accept && ovf) ? 1'b1 : sat_q;
  end
  always_ff @(posedge AB_clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      vld_q <= vld_d;
      sat_q <= sat_d;
    end
  end
endmodule
